// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: ID/EX hazard inputs and the
// PC / pipeline-register control outputs it returns.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        id_mdu_start;
  logic        id_mdu_is_div;
  logic        id_uses_hilo;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mdu_busy;
  logic        mdu_issue;
  logic [15:0] stall_count;

  // Pipeline datapath side: presents instruction info, obeys the controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, id_mdu_start, id_mdu_is_div, id_uses_hilo,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, mdu_busy, mdu_issue,
           stall_count
  );

  // Hazard controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, id_mdu_start, id_mdu_is_div, id_uses_hilo,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, mdu_busy, mdu_issue,
           stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use and HI/LO stalls, branch
// flushes, a multi-cycle MDU occupancy tracker and a saturating stall counter.
module pipeline_hazard_ctrl (
  input  logic                         clk,
  input  logic                         reset_n,
  pipeline_hazard_ctrl_if.slave        hz
);

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_t;

  localparam logic [4:0] MULT_CNT = 5'd3;
  localparam logic [4:0] DIV_CNT  = 5'd31;

  mdu_state_t  state_reg;
  logic [4:0]  mdu_cnt_reg;
  logic [15:0] stall_count_reg;

  logic rs_match;
  logic rt_match;
  logic load_use;
  logic hilo_hazard;
  logic stall;
  logic mdu_busy;
  logic mdu_issue;

  // Register $0 is hardwired to zero, so a load targeting it never hazards.
  assign rs_match    = hz.id_uses_rs && (hz.id_rs == hz.ex_rt);
  assign rt_match    = hz.id_uses_rt && (hz.id_rt == hz.ex_rt);
  assign load_use    = hz.ex_mem_read && (hz.ex_rt != 5'd0) && (rs_match || rt_match);
  assign mdu_busy    = (state_reg == MDU_RUN);
  assign hilo_hazard = mdu_busy && (hz.id_uses_hilo || hz.id_mdu_start);
  assign stall       = (load_use || hilo_hazard) && !hz.ex_branch_taken;

  // A taken branch squashes the ID instruction, so it must not launch the MDU.
  assign mdu_issue   = (state_reg == MDU_IDLE) && hz.id_mdu_start &&
                       !stall && !hz.ex_branch_taken;

  assign hz.pc_en       = !stall;
  assign hz.if_id_en    = !stall;
  assign hz.if_id_flush = hz.ex_branch_taken;
  assign hz.id_ex_flush = hz.ex_branch_taken || stall;
  assign hz.mdu_busy    = mdu_busy;
  assign hz.mdu_issue   = mdu_issue;
  assign hz.stall_count = stall_count_reg;

  // Branch flushes do not touch MDU_RUN: an issued op is already committed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= MDU_IDLE;
      mdu_cnt_reg <= 5'd0;
    end else begin
      case (state_reg)
        MDU_IDLE: begin
          if (mdu_issue) begin
            state_reg   <= MDU_RUN;
            mdu_cnt_reg <= hz.id_mdu_is_div ? DIV_CNT : MULT_CNT;
          end
        end
        MDU_RUN: begin
          if (mdu_cnt_reg == 5'd0) begin
            state_reg <= MDU_IDLE;
          end else begin
            mdu_cnt_reg <= mdu_cnt_reg - 5'd1;
          end
        end
        default: begin
          state_reg   <= MDU_IDLE;
          mdu_cnt_reg <= 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_reg <= 16'd0;
    end else if (stall && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ports: id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL have ports: ex_mem_read  in  1 (EX instruction is a load); ex_rt  in  5 (its destination).
REQ-006 SHALL have port: ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-007 SHALL have ports: id_mdu_start  in  1 (ID holds mult/div); id_mdu_is_div  in  1 (1 = div, 0 = mult); id_uses_hilo  in  1 (ID reads HI/LO).
REQ-008 SHALL have ports: pc_en, if_id_en, if_id_flush, id_ex_flush  out  1 each  pipeline control for PC, IF/ID and ID/EX registers.
REQ-009 SHALL have ports: mdu_busy  out  1; mdu_issue  out  1 (one-cycle MDU launch pulse); stall_count  out  16 (saturating performance counter).

Function
REQ-010 SHALL compute load_use = ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
REQ-011 SHALL compute hilo_hazard = mdu_busy & (id_uses_hilo | id_mdu_start).
REQ-012 SHALL define stall = (load_use | hilo_hazard) & ~ex_branch_taken.
REQ-013 SHALL drive pc_en = if_id_en = ~stall, combinationally, same cycle.
REQ-014 SHALL drive if_id_flush = ex_branch_taken; id_ex_flush = ex_branch_taken | stall.
REQ-015 SHALL give ex_branch_taken priority: flush both registers, pc_en = 1, no stall counted.
REQ-016 SHALL use FSM states MDU_IDLE and MDU_RUN; mdu_busy = (state == MDU_RUN).
REQ-017 SHALL, in MDU_IDLE with id_mdu_start & ~stall & ~ex_branch_taken, assert mdu_issue for that cycle, load 5-bit mdu_cnt with 3 (mult) or 31 (div), enter MDU_RUN next edge.
REQ-018 SHALL, in MDU_RUN, decrement mdu_cnt each edge; on edge with mdu_cnt == 0 return to MDU_IDLE (busy 4 cycles mult, 32 cycles div).
REQ-019 SHALL never assert mdu_issue in MDU_RUN; a second mult/div in ID stalls via REQ-011 until MDU_IDLE, then issues.
REQ-020 SHALL keep MDU_RUN running through branch flushes (issued op is architecturally committed).
REQ-021 SHALL increment stall_count on every edge where stall = 1; saturate at 16'hFFFF.
REQ-022 SHALL, with load_use and hilo_hazard both true, produce one stall cycle per cycle (no double count).
REQ-023 SHALL treat ex_rt == 0 as no hazard (register $0).

Reset
REQ-024 SHALL, on reset_n low, asynchronously set state = MDU_IDLE, mdu_cnt = 0, stall_count = 0.
REQ-025 SHALL, during and directly after reset with all inputs 0, output pc_en = 1, if_id_en = 1, if_id_flush = 0, id_ex_flush = 0, mdu_busy = 0, mdu_issue = 0.
REQ-026 SHALL abort an in-flight MDU operation on reset mid-operation (mdu_busy = 0 immediately, no issue pulse).

Verification
REQ-027 SHALL cover load-use: ex_mem_read = 1, ex_rt = 8, id_rs = 8, id_uses_rs = 1 for 1 cycle -> pc_en = 0, if_id_en = 0, id_ex_flush = 1, stall_count 0 -> 1.
REQ-028 SHALL cover branch vs load-use same cycle: both conditions true -> if_id_flush = 1, id_ex_flush = 1, pc_en = 1, stall_count unchanged.
REQ-029 SHALL cover div then HI/LO read: id_mdu_start = 1, id_mdu_is_div = 1 -> mdu_issue pulse 1 cycle, mdu_busy high exactly 32 cycles; id_uses_hilo = 1 held -> stall for those 32 cycles, released the cycle after mdu_busy falls.
REQ-030 SHALL cover back-to-back mult: mult issues, second mult in ID next cycle -> 4 stall cycles, second mdu_issue on the first cycle in MDU_IDLE.
REQ-031 SHALL cover reset mid-div: reset_n low at cycle 10 of a div -> mdu_busy = 0, stall_count = 0 asynchronously; after release, outputs per REQ-025.
REQ-032 SHALL cover saturation: force 65 536 stall cycles -> stall_count holds 16'hFFFF.
